// File: rtl/output_neuron_mac.sv
// Output-layer neuron: serial multiply-accumulate of hidden activations against
// signed weights plus bias, followed by ReLU and saturation to UQ3.7.
module output_neuron_mac #(
    parameter int NUM_HIDDEN = 4,
    parameter int ACC_W      = 22
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] bias_i,
    input  logic       h_valid_i,
    output logic       h_ready_o,
    input  logic [9:0] h_i,
    input  logic [7:0] w_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [9:0] out_o,
    output logic       fire_o,
    output logic       busy_o
);

    localparam int CNT_W = (NUM_HIDDEN > 1) ? $clog2(NUM_HIDDEN) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the producer holds its data stable while valid waits for ready.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACC    = 2'd1,
        S_RESULT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                   state_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic [CNT_W-1:0]         cnt_q;
    logic                     h_ready_q;
    logic                     out_valid_q;
    logic                     busy_q;
    logic                     fire_q;
    logic [9:0]               out_q;

    logic signed [17:0]       h_ext;
    logic signed [17:0]       w_ext;
    logic signed [17:0]       prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  r;
    logic [9:0]               res_d;
    logic                     beat;
    logic                     last_beat;

    // UQ3.7 x Q1.7 always fits 18 signed bits, so the truncating multiply is exact.
    assign h_ext    = $signed({8'b0, h_i});
    assign w_ext    = $signed({{10{w_i[7]}}, w_i});
    assign prod     = h_ext * w_ext;
    assign prod_ext = {{(ACC_W-18){prod[17]}}, prod};
    assign bias_ext = {{(ACC_W-15){bias_i[7]}}, bias_i, 7'b0};
    assign acc_d    = acc_q + prod_ext;

    assign beat      = h_valid_i & h_ready_q;
    assign last_beat = (cnt_q == CNT_W'(NUM_HIDDEN - 1));

    assign r = acc_q >>> 7;

    always_comb begin
        res_d = r[9:0];
        if (r[ACC_W-1]) begin
            res_d = 10'd0;
        end else if (|r[ACC_W-2:10]) begin
            res_d = 10'h3FF;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            h_ready_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            fire_q      <= 1'b0;
            out_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q   <= S_ACC;
                        acc_q     <= bias_ext;
                        cnt_q     <= '0;
                        h_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_ACC: begin
                    if (beat) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_beat) begin
                            state_q   <= S_RESULT;
                            h_ready_q <= 1'b0;
                        end
                    end
                end
                S_RESULT: begin
                    out_q       <= res_d;
                    fire_q      <= (res_d != 10'd0);
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign h_ready_o   = h_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_o       = out_q;
    assign fire_o      = fire_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_output_neuron_mac.sv
// Bench for output_neuron_mac: directed scenarios plus randomized inferences
// scored against an integer-arithmetic model of the neuron.
module tb_output_neuron_mac;

  localparam int NH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] bias = '0;
  logic       h_valid = 1'b0;
  logic       h_ready;
  logic [9:0] h = '0;
  logic [7:0] w = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [9:0] out;
  logic       fire;
  logic       busy;

  output_neuron_mac #(.NUM_HIDDEN(NH), .ACC_W(22)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .start_i    (start),
    .bias_i     (bias),
    .h_valid_i  (h_valid),
    .h_ready_o  (h_ready),
    .h_i        (h),
    .w_i        (w),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_o      (out),
    .fire_o     (fire),
    .busy_o     (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad = 0;
  logic [10:0] exp_q[$];   // {fire, out}
  int cur_h[NH];
  int cur_w[NH];
  int cur_bias;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference: bias*2^7 + sum(h*w), floor-divide by 2^7, ReLU, clamp to 1023
  function automatic logic [10:0] model_out();
    int sum;
    int r;
    logic [9:0] o;
    sum = cur_bias * 128;
    for (int i = 0; i < NH; i++) sum += cur_h[i] * cur_w[i];
    r = sum >>> 7;
    if (r < 0) r = 0;
    else if (r > 1023) r = 1023;
    o = 10'(r);
    return {(r != 0), o};
  endfunction

  task automatic set_all(input int hh, input logic [7:0] ww);
    for (int i = 0; i < NH; i++) begin
      cur_h[i] = hh;
      cur_w[i] = int'($signed(ww));
    end
  endtask

  // driver tasks: each is entered at a negedge and leaves at a negedge
  task automatic do_start(input logic [7:0] b);
    cur_bias = int'($signed(b));
    start = 1'b1;
    bias = b;
    @(negedge clk);
    start = 1'b0;
    bias = 8'($urandom);
    check_eq("start_busy", busy, 1);
    check_eq("start_ready", h_ready, 1);
    check_eq("start_valid", out_valid, 0);
  endtask

  // stall < 0: random 0..2 idle cycles before each beat; otherwise fixed count
  task automatic send_beats(input int n, input int stall);
    int s;
    for (int i = 0; i < n; i++) begin
      s = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      for (int j = 0; j < s; j++) begin
        h_valid = 1'b0;
        h = 10'($urandom);
        w = 8'($urandom);
        @(negedge clk);
        check_eq("stall_ready", h_ready, 1);
      end
      check_eq("beat_ready", h_ready, 1);
      h_valid = 1'b1;
      h = 10'(cur_h[i]);
      w = 8'(cur_w[i]);
      @(negedge clk);
      h_valid = 1'b0;
    end
  endtask

  task automatic finish_inference(input int hold);
    int k;
    logic [10:0] e;
    check_eq("result_valid_lo", out_valid, 0);
    check_eq("result_ready_lo", h_ready, 0);
    k = 1;
    while (!out_valid && k < 12) begin
      @(negedge clk);
      k++;
    end
    check_eq("latency", k, 2);
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 1, 0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check_eq("out", out, 32'(e[9:0]));
    check_eq("fire", fire, 32'(e[10]));
    for (int j = 0; j < hold; j++) begin
      start = 1'b1;
      bias = 8'h7F;
      out_ready = 1'b0;
      @(negedge clk);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_busy", busy, 1);
      check_eq("hold_out", out, 32'(e[9:0]));
      check_eq("hold_fire", fire, 32'(e[10]));
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("idle_valid", out_valid, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_ready", h_ready, 0);
    check_eq("idle_out_kept", out, 32'(e[9:0]));
  endtask

  task automatic run_inference(input logic [7:0] b, input logic [10:0] e,
                               input int stall, input int hold);
    exp_q.push_back(e);
    do_start(b);
    send_beats(NH, stall);
    finish_inference(hold);
  endtask

  initial begin
    // reset values
    #2;
    check_eq("rst_out", out, 0);
    check_eq("rst_fire", fire, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_ready", h_ready, 0);
    check_eq("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic MAC: 4 x (1.0 * 0.5) = 2.0
    set_all(128, 8'h40);
    run_inference(8'h00, {1'b1, 10'd256}, 0, 0);

    // negative sum clipped by ReLU
    set_all(128, 8'hC0);
    run_inference(8'h00, {1'b0, 10'd0}, 0, 0);

    // saturation with bias
    set_all(1023, 8'h7F);
    run_inference(8'h7F, {1'b1, 10'd1023}, 0, 0);

    // bias only, two idle cycles before every beat
    set_all(1023, 8'h00);
    run_inference(8'h40, {1'b1, 10'd64}, 2, 0);

    // backpressure with ignored starts, then a fresh start right after release
    set_all(1023, 8'h7F);
    run_inference(8'h00, {1'b1, 10'd1023}, 0, 10);
    set_all(500, 8'h00);
    run_inference(8'h20, {1'b1, 10'd32}, 0, 0);

    // reset mid-inference after two beats
    set_all(128, 8'h40);
    do_start(8'h00);
    send_beats(2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out", out, 0);
    check_eq("mid_rst_fire", fire, 0);
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_ready", h_ready, 0);
    check_eq("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_inference(8'h00, {1'b1, 10'd256}, 0, 0);

    // randomized inferences scored by the reference model
    for (int n = 0; n < 40; n++) begin
      logic [7:0] rb;
      rb = 8'($urandom);
      cur_bias = int'($signed(rb));
      for (int i = 0; i < NH; i++) begin
        cur_h[i] = int'($urandom_range(0, 1023));
        cur_w[i] = int'($signed(8'($urandom)));
      end
      run_inference(rb, model_out(), -1, int'($urandom_range(0, 3)));
    end

    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_neuron_mac.md
Name: output_neuron_mac

Overview:
Output-layer neuron that consumes the registered 10-bit hidden-layer activations one per beat. Each activation is multiplied by a signed weight and accumulated with a bias. The sum then passes through ReLU and saturation, and the result is presented on a valid/ready output. It sits directly downstream of the hidden-neuron bank and replaces a parallel adder tree with a serial MAC driven by a small FSM.

Parameters:
NUM_HIDDEN, 4, number of activation beats per inference (>=1)
ACC_W, 22, signed accumulator width; must be >= 18 + ceil(log2(NUM_HIDDEN+1))

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous active-low reset
start_i  input  1  begin inference; sampled only in IDLE
bias_i  input  8  signed Q1.7 bias; captured on accepted start
h_valid_i  input  1  activation beat valid
h_ready_o  output  1  block can accept an activation beat
h_i  input  10  unsigned UQ3.7 hidden activation
w_i  input  8  signed Q1.7 weight paired with h_i
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
out_o  output  10  unsigned UQ3.7 result (ReLU, saturated)
fire_o  output  1  out_o != 0; valid with out_valid_o
busy_o  output  1  state != IDLE

Behaviour:
- Reset (rst_i low, any time, async):
  - state=IDLE, acc=0, cnt=0.
  - out_o=0, fire_o=0, out_valid_o=0, h_ready_o=0, busy_o=0.
  - Any in-flight inference is discarded; no partial result is ever emitted.
- FSM states: IDLE, ACC, RESULT, DONE.
- IDLE:
  - h_ready_o=0.
  - start_i=1 -> ACC next cycle; acc <= sign_extend(bias_i) <<< 7 (aligned to Q.14); cnt <= 0.
- ACC:
  - h_ready_o=1.
  - Beat accepted when h_valid_i & h_ready_o.
  - Per accepted beat: acc <= acc + sign_extend({0,h_i} * w_i). The product is 18-bit signed Q4.14.
  - cnt <= cnt+1 per beat.
  - The beat with cnt==NUM_HIDDEN-1 goes -> RESULT.
  - Cycles with h_valid_i=0 leave acc and cnt unchanged; no timeout.
- RESULT (1 cycle):
  - h_ready_o=0.
  - r = acc >>> 7 (arithmetic shift, floor).
  - out_o <= 0 if r<0; 1023 if r>1023; else r[9:0].
  - fire_o <= (result != 0).
  - -> DONE.
- DONE:
  - out_valid_o=1; out_o and fire_o held stable.
  - On out_ready_i=1: out_valid_o deasserts next cycle; -> IDLE.
  - out_o and fire_o retain their last value in IDLE.
- Latency:
  - out_valid_o rises 2 cycles after the clock edge accepting the final beat.
  - Minimum inference = 1 (start) + NUM_HIDDEN + 2 cycles to valid.
  - Back-to-back: start_i may be asserted the cycle after the DONE handshake.
- start_i outside IDLE is ignored; a new bias_i is not captured.
- No overflow is possible in acc given the ACC_W rule; saturation exists only at the output.
- Multiply is combinational within the beat cycle; no pipeline beyond the state registers.

Test Plan:
1. Basic MAC: NUM_HIDDEN=4, bias=0x00, four beats h=128 (1.0), w=0x40 (0.5) -> out_o=256, fire_o=1; out_valid_o rises exactly 2 cycles after the 4th accept.
2. Negative/ReLU: bias=0x00, h=128, w=0xC0 (-0.5) on all beats -> acc=-32768, out_o=0, fire_o=0.
3. Saturation + bias: bias=0x7F, h=1023, w=0x7F on all beats -> acc=535940, r=4187, out_o=1023, fire_o=1.
4. Bias only, with stalls: bias=0x40, w=0 on all beats, h_valid_i toggled 1,0,0,1,... -> out_o=64. cnt advances only on accepts. h_ready_o=1 throughout ACC.
5. Output backpressure + ignored start: hold out_ready_i=0 for 10 cycles in DONE while pulsing start_i with bias=0x7F. Required: out_o/fire_o stable, no state change, old bias kept. Release -> IDLE one cycle later; next start accepted.
6. Reset mid-operation: assert rst_i low after 2 of 4 beats. Required: all outputs 0 asynchronously, state IDLE. After release, a fresh scenario-1 inference -> out_o=256 with no residue from the aborted run.
